// File: rtl/boot_button_sequencer.sv
// Power-up / front-panel sequencer: debounces r,b,h,c buttons, sequences reset -> boot delay -> boot pulse, then maps presses to core requests.
// Latency: button edge to output = 2 sync + DEBOUNCE_MAX + 1 debounce update + 1 press register + 1 output register cycles.
// Backpressure: none; presses arriving in states that ignore them are dropped, and an active interrupt pulse is never retriggered.
module boot_button_sequencer #(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd1000000,
  parameter int unsigned RESET_CYCLES = 64,
  parameter int unsigned BOOT_DELAY   = 16,
  parameter int unsigned PULSE_CYCLES = 8
) (
  input  logic       sysclk_buf,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic       button_r,
  input  logic       button_b,
  input  logic       button_h,
  input  logic       button_c,
  output logic       cpu_reset,
  output logic       boot,
  output logic       halt,
  output logic       interrupt,
  output logic [2:0] state_out
);

  localparam int unsigned CNT_MAX0 = (RESET_CYCLES > BOOT_DELAY) ? RESET_CYCLES : BOOT_DELAY;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > PULSE_CYCLES) ? CNT_MAX0 : PULSE_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned PW       = $clog2(PULSE_CYCLES + 1);

  localparam logic [CW-1:0] LOAD_RESET = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_DELAY = CW'(BOOT_DELAY - 1);
  localparam logic [CW-1:0] LOAD_BOOT  = CW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] LOAD_INT   = PW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd0,
    S_RESET      = 3'd1,
    S_BOOT_DELAY = 3'd2,
    S_BOOT       = 3'd3,
    S_RUN        = 3'd4
  } state_t;

  // Button bit order everywhere below: [0]=r, [1]=b, [2]=h, [3]=c.
  logic [3:0]  btn_raw;
  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [3:0]  deb_q;
  logic [3:0]  deb_prev_q;
  logic [3:0]  press_q;
  logic [19:0] db_cnt_q [4];

  logic press_r;
  logic press_b;
  logic press_h;
  logic press_c;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halt_q, halt_d;
  logic          int_q, int_d;
  logic [PW-1:0] int_cnt_q, int_cnt_d;
  logic          cpu_reset_q;
  logic          boot_q;

  assign btn_raw = {button_c, button_h, button_b, button_r};
  assign press_r = press_q[0];
  assign press_b = press_q[1];
  assign press_h = press_q[2];
  assign press_c = press_q[3];

  // Synchronize, debounce and edge-detect the four buttons; a press is a 1-cycle pulse on a debounced rise.
  always_ff @(posedge sysclk_buf) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DEBOUNCE_MAX) begin
            deb_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 20'd1;
          end
        end else begin
          // Agreement at any point restarts the qualification window.
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Next-state logic: lock loss beats a reset press, which beats everything the current state would do.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    halt_d    = halt_q;
    int_d     = int_q;
    int_cnt_d = int_cnt_q;

    if ((state_q != S_WAIT_LOCK) && !dcm_locked) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
    end else if ((state_q != S_WAIT_LOCK) && press_r) begin
      state_d = S_RESET;
      cnt_d   = LOAD_RESET;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (dcm_locked) begin
            state_d = S_RESET;
            cnt_d   = LOAD_RESET;
          end
        end
        S_RESET: begin
          if (cnt_q == '0) begin
            state_d = S_BOOT_DELAY;
            cnt_d   = LOAD_DELAY;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_BOOT_DELAY: begin
          if (cnt_q == '0) begin
            state_d = S_BOOT;
            cnt_d   = LOAD_BOOT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_BOOT: begin
          if (cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_RUN: begin
          if (press_b) begin
            state_d = S_BOOT_DELAY;
            cnt_d   = LOAD_DELAY;
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    // Halt is held clear through lock wait and reset, so an h press coincident with r is lost.
    if ((state_d == S_WAIT_LOCK) || (state_d == S_RESET)) begin
      halt_d = 1'b0;
    end else if (press_h && ((state_q == S_RUN) || (state_q == S_BOOT))) begin
      halt_d = ~halt_q;
    end

    // Interrupt pulse lives only while the FSM stays in S_RUN; presses during a pulse are ignored.
    if ((state_q != S_RUN) || (state_d != S_RUN)) begin
      int_d     = 1'b0;
      int_cnt_d = '0;
    end else if (int_q) begin
      if (int_cnt_q == '0) begin
        int_d = 1'b0;
      end else begin
        int_cnt_d = int_cnt_q - PW'(1);
      end
    end else if (press_c) begin
      int_d     = 1'b1;
      int_cnt_d = LOAD_INT;
    end
  end

  // FSM register; outputs are decoded from the next state so they change on the same edge as state_out.
  always_ff @(posedge sysclk_buf) begin
    if (reset) begin
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= '0;
      halt_q      <= 1'b0;
      int_q       <= 1'b0;
      int_cnt_q   <= '0;
      cpu_reset_q <= 1'b1;
      boot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_d;
      int_q       <= int_d;
      int_cnt_q   <= int_cnt_d;
      cpu_reset_q <= (state_d == S_WAIT_LOCK) || (state_d == S_RESET);
      boot_q      <= (state_d == S_BOOT);
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign boot      = boot_q;
  assign halt      = halt_q;
  assign interrupt = int_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_boot_button_sequencer.sv
// Bench for boot_button_sequencer: table-driven power-up vectors plus hand-written button sequences.
// Latency: inputs driven on negedge, outputs sampled on the following negedge (one posedge later).
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_boot_button_sequencer;

  localparam logic [19:0] DM = 20'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [3:0] btn;   // [0]=r [1]=b [2]=h [3]=c
  logic       cpu_reset, boot, halt, interrupt;
  logic [2:0] state_out;

  always #10 clk = ~clk;

  boot_button_sequencer #(
    .DEBOUNCE_MAX (DM),
    .RESET_CYCLES (8),
    .BOOT_DELAY   (4),
    .PULSE_CYCLES (4)
  ) dut (
    .sysclk_buf (clk),
    .reset      (rst),
    .dcm_locked (lock),
    .button_r   (btn[0]),
    .button_b   (btn[1]),
    .button_h   (btn[2]),
    .button_c   (btn[3]),
    .cpu_reset  (cpu_reset),
    .boot       (boot),
    .halt       (halt),
    .interrupt  (interrupt),
    .state_out  (state_out)
  );

  // Expected output word: {cpu_reset, boot, halt, interrupt, state[2:0]}
  typedef struct {
    logic       rst;
    logic       lock;
    int         n;
    logic [6:0] expv;
  } vec_t;

  vec_t vecs [6];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         tick_no  = 0;
  int         cr_n, boot_n, int_n, int_rise, int_first;
  logic       int_prev = 1'b0;
  logic [2:0] prev_state = 3'd0;
  logic [2:0] leave_state;
  int         t0;

  function automatic logic [6:0] outs();
    return {cpu_reset, boot, halt, interrupt, state_out};
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic clear_counts();
    cr_n        = 0;
    boot_n      = 0;
    int_n       = 0;
    int_rise    = 0;
    int_first   = -1;
    leave_state = 3'd7;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    tick_no++;
    if (cpu_reset) cr_n++;
    if (boot) boot_n++;
    if (interrupt) int_n++;
    if (interrupt && !int_prev) begin
      int_rise++;
      if (int_first < 0) int_first = tick_no;
    end
    int_prev = interrupt;
    if ((prev_state == 3'd4) && (state_out != 3'd4) && (leave_state == 3'd7))
      leave_state = state_out;
    prev_state = state_out;
  endtask

  task automatic apply_rows(input int first, input int last, input string tag);
    for (int r = first; r <= last; r++) begin
      rst  = vecs[r].rst;
      lock = vecs[r].lock;
      for (int k = 0; k < vecs[r].n; k++) begin
        tick();
        check($sformatf("%s_row%0d_cyc%0d", tag, r, k), int'(outs()), int'(vecs[r].expv));
      end
    end
  endtask

  task automatic press_button(input int idx, input int hold);
    btn[idx] = 1'b1;
    repeat (hold) tick();
    btn[idx] = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k;
    k = 0;
    while ((state_out != s) && (k < budget)) begin
      tick();
      k++;
    end
    check(name, int'(state_out), int'(s));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3,  7'b1000_000};  // reset asserted
    vecs[1] = '{1'b0, 1'b0, 10, 7'b1000_000};  // waiting for lock
    vecs[2] = '{1'b0, 1'b1, 8,  7'b1000_001};  // S_RESET
    vecs[3] = '{1'b0, 1'b1, 4,  7'b0000_010};  // S_BOOT_DELAY
    vecs[4] = '{1'b0, 1'b1, 4,  7'b0100_011};  // S_BOOT
    vecs[5] = '{1'b0, 1'b1, 5,  7'b0000_100};  // S_RUN

    rst  = 1'b1;
    lock = 1'b0;
    btn  = 4'b0000;
    clear_counts();

    // Power-up sequence
    apply_rows(0, 5, "powerup");

    // Glitch on c is rejected, a held press gives one 4-cycle pulse
    clear_counts();
    press_button(3, 3);
    check("glitch_int_cycles", int_n, 0);
    clear_counts();
    t0 = tick_no;
    press_button(3, 20);
    check("int_cycles", int_n, 4);
    check("int_rises", int_rise, 1);
    check("int_latency", int_first - t0, 9);

    // Halt toggles on each press
    press_button(2, 10);
    check("halt_first", int'(halt), 1);
    press_button(2, 10);
    check("halt_second", int'(halt), 0);
    press_button(2, 10);
    check("halt_third", int'(halt), 1);

    // Reset press clears halt and reruns reset/boot
    clear_counts();
    press_button(0, 10);
    repeat (10) tick();
    check("rpress_reset_cycles", cr_n, 8);
    check("rpress_boot_cycles", boot_n, 4);
    check("rpress_halt", int'(halt), 0);
    check("rpress_state", int'(state_out), 4);
    check("rpress_leave_state", int'(leave_state), 1);

    // Lock loss during S_BOOT (reached via a reboot press)
    btn[1] = 1'b1;
    wait_state(3'd3, 40, "reboot_reach_boot");
    check("reboot_boot_high", int'(boot), 1);
    lock = 1'b0;
    tick();
    check("lockloss_outputs", int'(outs()), int'(7'b1000_000));
    btn[1] = 1'b0;
    apply_rows(2, 5, "relock");

    // Simultaneous r and b: reset wins
    clear_counts();
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    repeat (10) tick();
    btn = 4'b0000;
    repeat (22) tick();
    check("simul_leave_state", int'(leave_state), 1);
    check("simul_reset_cycles", cr_n, 8);
    check("simul_boot_cycles", boot_n, 4);
    check("simul_state", int'(state_out), 4);

    // Synchronous reset in the middle of an interrupt pulse with halt set
    press_button(2, 10);
    check("mid_halt_set", int'(halt), 1);
    btn[3] = 1'b1;
    begin
      int k;
      k = 0;
      while (!interrupt && (k < 30)) begin
        tick();
        k++;
      end
    end
    check("mid_int_high", int'(interrupt), 1);
    rst = 1'b1;
    tick();
    check("mid_reset_outputs", int'(outs()), int'(7'b1000_000));
    rst = 1'b0;
    tick();
    check("mid_after_release", int'(outs()), int'(7'b1000_001));
    btn[3] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
